wide_cmp_seq: RTL

WIDE_CMP_SEQ -- requirements
Module: wide_cmp_seq

---
 rtl/wide_cmp_seq_pkg.sv | 13 +
 rtl/wide_cmp_seq_cmp2_slice.sv | 22 ++
 rtl/wide_cmp_seq.sv | 115 +++++++++++
 3 files changed

// File: rtl/wide_cmp_seq_pkg.sv
// Shared definitions for the sequential wide comparator.
// Holds the FSM state encoding and the default slice count.
package wide_cmp_seq_pkg;

    localparam int N_SLICES_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_COMPARE = 2'b01,
        S_DONE    = 2'b10
    } state_t;

endpackage

// File: rtl/wide_cmp_seq_cmp2_slice.sv
// Combinational 2-bit magnitude comparator slice.
// a1/a2, b1/b2: operand bits (x1 = MSB); f1 A>B, f2 A==B, f3 A<B.
module cmp2_slice (
    input  logic a1,
    input  logic a2,
    input  logic b1,
    input  logic b2,
    output logic f1,
    output logic f2,
    output logic f3
);

    logic [1:0] a;
    logic [1:0] b;

    assign a  = {a1, a2};
    assign b  = {b1, b2};
    assign f1 = (a > b);
    assign f2 = (a == b);
    assign f3 = (a < b);

endmodule

// File: rtl/wide_cmp_seq.sv
// Sequential MSB-first comparator, one 2-bit slice per cycle.
// Ports: clk, rst_n, start, op_a/op_b in; busy, done, gt/eq/lt, slices_used out.
module wide_cmp_seq
    import wide_cmp_seq_pkg::*;
#(
    parameter int N_SLICES = N_SLICES_DEF,
    parameter int W        = 2 * N_SLICES,
    parameter int SUW      = $clog2(N_SLICES) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   op_a,
    input  logic [W-1:0]   op_b,
    output logic           busy,
    output logic           done,
    output logic           gt,
    output logic           eq,
    output logic           lt,
    output logic [SUW-1:0] slices_used
);

    localparam int IW = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam logic [IW-1:0] IDX_MSB = IW'(N_SLICES - 1);

    state_t        state;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [1:0]    a_sl;
    logic [1:0]    b_sl;
    logic          s_gt;
    logic          s_eq;
    logic          s_lt;

    // Slice mux: pick the 2-bit pair addressed by idx.
    always_comb begin
        a_sl = 2'b00;
        b_sl = 2'b00;
        for (int i = 0; i < N_SLICES; i++) begin
            if (idx == IW'(i)) begin
                a_sl = a_q[2*i +: 2];
                b_sl = b_q[2*i +: 2];
            end
        end
    end

    cmp2_slice u_slice (
        .a1 (a_sl[1]),
        .a2 (a_sl[0]),
        .b1 (b_sl[1]),
        .b2 (b_sl[0]),
        .f1 (s_gt),
        .f2 (s_eq),
        .f3 (s_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx         <= IDX_MSB;
            a_q         <= '0;
            b_q         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            gt          <= 1'b0;
            eq          <= 1'b0;
            lt          <= 1'b0;
            slices_used <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q         <= op_a;
                        b_q         <= op_b;
                        idx         <= IDX_MSB;
                        gt          <= 1'b0;
                        eq          <= 1'b0;
                        lt          <= 1'b0;
                        slices_used <= '0;
                        busy        <= 1'b1;
                        state       <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    slices_used <= slices_used + 1'b1;
                    if (!s_eq) begin
                        // First unequal slice decides; stop early.
                        gt    <= s_gt;
                        lt    <= s_lt;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (idx == '0) begin
                        eq    <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
